// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt pending controller.
// Eight request lines, 3-bit ids, three-state presentation FSM.
package irq_pkg;

  localparam int IRQ_N    = 8;
  localparam int IRQ_ID_W = 3;

  localparam logic [IRQ_N-1:0] IRQ_MASK_RST = 8'h00;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_CLEAR   = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_prio_enc8.sv
// 8->3 highest-index priority encoder with an all-zero flag.
// Latency: combinational. Backpressure: none.
module irq_prio_enc8
  import irq_pkg::*;
(
  input  logic [IRQ_N-1:0]    eff,
  output logic [IRQ_ID_W-1:0] id,
  output logic                none
);

  // Ascending scan: the last (highest) set index overwrites lower ones.
  always_comb begin
    id = '0;
    for (int i = 0; i < IRQ_N; i++) begin
      if (eff[i]) id = IRQ_ID_W'(i);
    end
    none = (eff == '0);
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Pending/mask register with a valid/ack presenter; edge mode via IRQ_EDGE_DETECT_EN.
// Latency: irq_valid one cycle after the pending bit sets; one idle cycle after every ack.
// Backpressure: a presented id is held until ack; new requests accumulate in pending.
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int N    = IRQ_N,
  parameter int ID_W = IRQ_ID_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            mask_wr,
  input  logic [N-1:0]    mask_in,
  input  logic            ack,
  output logic            irq_valid,
  output logic [ID_W-1:0] irq_id,
  output logic [N-1:0]    pending,
  output logic            idle
);

  irq_state_t      state, state_d;
  logic [N-1:0]    mask_q, mask_d;
  logic [N-1:0]    pending_d;
  logic [N-1:0]    set_vec, clr_vec;
  logic [N-1:0]    eff;
  logic [ID_W-1:0] win_id;
  logic            win_none;
  logic            ack_fire;
  logic            load_id;
  logic            idle_d;

`ifdef IRQ_EDGE_DETECT_EN
  logic [N-1:0] req_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_q <= '0;
    else     req_q <= req;
  end

  assign set_vec = req & ~req_q;
`else
  assign set_vec = req;
`endif

  assign ack_fire  = (state == S_PRESENT) && ack;
  assign clr_vec   = ack_fire ? (N'(1) << irq_id) : '0;
  // Set is applied after clear so a same-cycle request keeps the bit pending.
  assign pending_d = (pending & ~clr_vec) | set_vec;
  assign mask_d    = mask_wr ? mask_in : mask_q;
  assign eff       = pending & ~mask_q;

  irq_prio_enc8 u_enc (
    .eff  (eff),
    .id   (win_id),
    .none (win_none)
  );

  always_comb begin
    state_d = state;
    load_id = 1'b0;
    case (state)
      S_IDLE, S_CLEAR: begin
        if (!win_none) begin
          state_d = S_PRESENT;
          load_id = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRESENT: begin
        if (ack) state_d = S_CLEAR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered from next-cycle values so idle lines up with state and pending.
  assign idle_d = (state_d == S_IDLE) && ((pending_d & ~mask_d) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      mask_q    <= IRQ_MASK_RST;
      pending   <= '0;
      irq_valid <= 1'b0;
      irq_id    <= '0;
      idle      <= 1'b1;
    end else begin
      state     <= state_d;
      mask_q    <= mask_d;
      pending   <= pending_d;
      irq_valid <= (state_d == S_PRESENT);
      idle      <= idle_d;
      if (load_id) irq_id <= win_id;
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Randomized + directed bench for irq_pending_ctrl with a queue-based scoreboard
// fed by a set/integer reference model; honours IRQ_EDGE_DETECT_EN.
module tb_irq_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       mask_wr;
  logic [7:0] mask_in;
  logic       ack;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic       idle;

  always #5 clk = ~clk;

  irq_pending_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mask_wr   (mask_wr),
    .mask_in   (mask_in),
    .ack       (ack),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .pending   (pending),
    .idle      (idle)
  );

  int vectors     = 0;
  int miscompares = 0;
  int exp_q[$];
  int seen[$];
  int want[$];

  // Reference model: pending as a bit set, presented line as an integer (-1 = none).
  logic [7:0] m_pend, m_mask, m_req_q;
  int         m_shown;
  bit         m_gap;
  bit         m_idle;

  bit         mon_en = 1'b0;
  bit         prev_valid = 1'b0;
  logic [2:0] held_id = 3'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic int top_bit(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_pend  = 8'h00;
    m_mask  = 8'h00;
    m_req_q = 8'h00;
    m_shown = -1;
    m_gap   = 1'b0;
    m_idle  = 1'b1;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [7:0] eff, setv, np, nm;
    int ns;
    bit ng;
    eff = m_pend & ~m_mask;
`ifdef IRQ_EDGE_DETECT_EN
    setv = req & ~m_req_q;
`else
    setv = req;
`endif
    np = m_pend;
    ns = m_shown;
    ng = 1'b0;
    if (m_shown >= 0) begin
      if (ack) begin
        np[m_shown] = 1'b0;
        ns = -1;
        ng = 1'b1;
      end
    end else if (eff != 8'h00) begin
      ns = top_bit(eff);
      exp_q.push_back(ns);
    end
    np = np | setv;
    nm = mask_wr ? mask_in : m_mask;
    m_pend  = np;
    m_mask  = nm;
    m_shown = ns;
    m_gap   = ng;
    m_req_q = req;
    m_idle  = (ns < 0) && !ng && ((np & ~nm) == 8'h00);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    #1;
  endtask

  // Monitor: per-cycle state checks plus scoreboard pop on each new presentation.
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      prev_valid = 1'b0;
    end else begin
      check("valid", irq_valid, m_shown >= 0);
      check("pending", pending, m_pend);
      check("idle", idle, m_idle);
      if (irq_valid && !prev_valid) begin
        if (exp_q.size() == 0) fail_now("unexpected_presentation");
        else check("irq_id", irq_id, exp_q.pop_front());
        seen.push_back(int'(irq_id));
        held_id = irq_id;
      end else if (irq_valid) begin
        check("id_stable", irq_id, held_id);
      end
      prev_valid = irq_valid;
    end
  end

  task automatic pulse(input logic [7:0] v);
    req = v;
    tick();
    req = 8'h00;
  endtask

  task automatic wait_valid(input string name, input int maxc);
    int n = 0;
    while (!irq_valid) begin
      tick();
      n++;
      if (n > maxc) begin
        fail_now(name);
        break;
      end
    end
  endtask

  task automatic drain(input string name, input int maxc);
    int n = 0;
    while (!(idle && !irq_valid)) begin
      ack = irq_valid;
      tick();
      ack = 1'b0;
      n++;
      if (n > maxc) begin
        fail_now(name);
        break;
      end
    end
    ack = 1'b0;
  endtask

  task automatic check_seen(input string name, input int w[$]);
    check({name, "_count"}, seen.size(), w.size());
    for (int i = 0; i < w.size() && i < seen.size(); i++)
      check($sformatf("%s_%0d", name, i), seen[i], w[i]);
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; mask_wr = 1'b0; mask_in = 8'h00; ack = 1'b0;
    model_reset();
    #1;
    check("rst_valid", irq_valid, 0);
    check("rst_id", irq_id, 0);
    check("rst_idle", idle, 1);
    check("rst_pending", pending, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Priority order, highest index first.
    seen.delete();
    pulse(8'b0011_0011);
    drain("prio_drain", 40);
    want = '{5, 4, 1, 0};
    check_seen("prio", want);
    check("prio_idle", idle, 1);

    // Masked line stays pending; unmasking makes it win next.
    seen.delete();
    mask_wr = 1'b1; mask_in = 8'h80; tick(); mask_wr = 1'b0;
    pulse(8'b1101_1011);
    wait_valid("mask_wait", 10);
    check("mask_first", irq_id, 6);
    check("mask_bit7_pending", pending[7], 1);
    mask_wr = 1'b1; mask_in = 8'h00; tick(); mask_wr = 1'b0;
    check("mask_hold", irq_id, 6);
    drain("mask_drain", 60);
    want = '{6, 7, 4, 3, 1, 0};
    check_seen("mask", want);

    // No preemption by a higher line.
    seen.delete();
    pulse(8'h02);
    wait_valid("nopre_wait", 10);
    pulse(8'h80);
    tick();
    check("nopre_hold", irq_id, 1);
    drain("nopre_drain", 40);
    want = '{1, 7};
    check_seen("nopre", want);

    // Request collides with the ack clearing the same bit.
    seen.delete();
    pulse(8'h08);
    wait_valid("coll_wait", 10);
    req = 8'h08; ack = 1'b1;
    tick();
    req = 8'h00; ack = 1'b0;
    check("coll_pending", pending[3], 1);
    drain("coll_drain", 40);
    want = '{3, 3};
    check_seen("coll", want);

    // Held request: edge mode presents once, level mode keeps re-presenting.
    seen.delete();
    req = 8'h01;
    for (int i = 0; i < 5; i++) begin
      ack = irq_valid;
      tick();
      ack = 1'b0;
    end
    req = 8'h00;
    drain("mode_drain", 40);
`ifdef IRQ_EDGE_DETECT_EN
    check("mode_count", seen.size(), 1);
`else
    check("mode_count_ge2", seen.size() >= 2, 1);
`endif
    if (seen.size() > 0) check("mode_id", seen[0], 0);

    // Asynchronous reset while presenting; requests during reset are dropped.
    pulse(8'h09);
    wait_valid("rst_wait", 10);
    check("rst_pre_id", irq_id, 3);
    check("rst_pre_pending", pending, 8'h09);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", irq_valid, 0);
    check("arst_id", irq_id, 0);
    check("arst_idle", idle, 1);
    check("arst_pending", pending, 0);
    model_reset();
    req = 8'hFF;
    tick();
    req = 8'h00;
    rst = 1'b0;
    tick();
    check("rst_nocapture", pending, 0);

    // Randomized traffic, including ack outside a presentation and mask churn.
    for (int i = 0; i < 800; i++) begin
      req     = 8'($urandom & $urandom & $urandom);
      mask_wr = ($urandom_range(0, 15) == 0);
      mask_in = 8'($urandom & $urandom);
      ack     = ($urandom_range(0, 2) == 0);
      tick();
    end
    req = 8'h00; ack = 1'b0;
    mask_wr = 1'b1; mask_in = 8'h00; tick(); mask_wr = 1'b0;
    drain("rand_drain", 200);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
